// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, ALU op codes and the ID/EX record.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_NOR = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5,
    ALU_SLT = 3'd6
  } aluOp_e;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // Stored ID/EX fields; the use flags are not kept because forwarding ignores them.
  typedef struct packed {
    logic              valid;
    aluOp_e            aluControl;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rsVal;
    logic [DATA_W-1:0] rtVal;
    logic [DATA_W-1:0] imm;
    logic              useImm;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
  } idExReg_t;

  localparam idExReg_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode, producer and EX-side signals of the ID/EX stage.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned REG_W  = cpu_pkg::REG_W
);
  logic              flush;
  logic              id_valid;
  logic [2:0]        id_alu_control;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [DATA_W-1:0] id_rs_val;
  logic [DATA_W-1:0] id_rt_val;
  logic [DATA_W-1:0] id_imm;
  logic              id_use_imm;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              mem_reg_write;
  logic [REG_W-1:0]  mem_rd;
  logic [DATA_W-1:0] mem_result;
  logic              wb_reg_write;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              stall_out;
  logic              ex_valid;
  logic [2:0]        ex_alu_control;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;

  modport master (
    output flush, id_valid, id_alu_control, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_rs_val, id_rt_val, id_imm, id_use_imm, id_reg_write, id_mem_read, id_mem_write,
           mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_data,
    input  stall_out, ex_valid, ex_alu_control, ex_a, ex_b, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  flush, id_valid, id_alu_control, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_rs_val, id_rt_val, id_imm, id_use_imm, id_reg_write, id_mem_read, id_mem_write,
           mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_data,
    output stall_out, ex_valid, ex_alu_control, ex_a, ex_b, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/id_ex_stage_forward_mux.sv
// Per-operand forwarding select: EX/MEM over MEM/WB, never into r0.
module forward_mux
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0]  idx,
  input  logic [DATA_W-1:0] storedVal,
  input  logic              memRegWrite,
  input  logic [REG_W-1:0]  memRd,
  input  logic [DATA_W-1:0] memResult,
  input  logic              wbRegWrite,
  input  logic [REG_W-1:0]  wbRd,
  input  logic [DATA_W-1:0] wbData,
  output logic [DATA_W-1:0] fwdVal
);

  // Pick the youngest matching producer for this source index.
  always_comb begin
    fwdVal = storedVal;
    if (idx != REG_ZERO) begin
      if (memRegWrite && (memRd == idx)) fwdVal = memResult;
      else if (wbRegWrite && (wbRd == idx)) fwdVal = wbData;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and operand forwarding.
module id_ex_stage
  import cpu_pkg::*;
(
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);

  idExReg_t          exReg;
  idExReg_t          idFields;
  logic              hazard;
  logic              stall;
  logic [DATA_W-1:0] rsFwd;
  logic [DATA_W-1:0] rtFwd;

  // Gather decode fields into the stored record.
  always_comb begin
    idFields            = ID_EX_BUBBLE;
    idFields.valid      = bus.id_valid;
    idFields.aluControl = aluOp_e'(bus.id_alu_control);
    idFields.rs         = bus.id_rs;
    idFields.rt         = bus.id_rt;
    idFields.rd         = bus.id_rd;
    idFields.rsVal      = bus.id_rs_val;
    idFields.rtVal      = bus.id_rt_val;
    idFields.imm        = bus.id_imm;
    idFields.useImm     = bus.id_use_imm;
    idFields.regWrite   = bus.id_reg_write;
    idFields.memRead    = bus.id_mem_read;
    idFields.memWrite   = bus.id_mem_write;
  end

  // Load-use hazard against the load currently in EX; a flush overrides the stall.
  always_comb begin
    hazard = exReg.valid && exReg.memRead && (exReg.rd != REG_ZERO) && bus.id_valid &&
             ((bus.id_uses_rs && (bus.id_rs == exReg.rd)) ||
              (bus.id_uses_rt && (bus.id_rt == exReg.rd)));
    stall  = hazard && !bus.flush;
  end

  // Pipeline register: reset, flush and stall all load a bubble.
  always_ff @(posedge clk) begin
    if (reset || bus.flush || stall) exReg <= ID_EX_BUBBLE;
    else                             exReg <= idFields;
  end

  forward_mux rsMux (
    .idx(exReg.rs), .storedVal(exReg.rsVal),
    .memRegWrite(bus.mem_reg_write), .memRd(bus.mem_rd), .memResult(bus.mem_result),
    .wbRegWrite(bus.wb_reg_write), .wbRd(bus.wb_rd), .wbData(bus.wb_data),
    .fwdVal(rsFwd)
  );

  forward_mux rtMux (
    .idx(exReg.rt), .storedVal(exReg.rtVal),
    .memRegWrite(bus.mem_reg_write), .memRd(bus.mem_rd), .memResult(bus.mem_result),
    .wbRegWrite(bus.wb_reg_write), .wbRd(bus.wb_rd), .wbData(bus.wb_data),
    .fwdVal(rtFwd)
  );

  // Drive the EX-side outputs from the stored record and forwarded operands.
  always_comb begin
    bus.stall_out      = stall;
    bus.ex_valid       = exReg.valid;
    bus.ex_alu_control = exReg.aluControl;
    bus.ex_a           = rsFwd;
    bus.ex_b           = exReg.useImm ? exReg.imm : rtFwd;
    bus.ex_store_data  = rtFwd;
    bus.ex_rd          = exReg.rd;
    bus.ex_reg_write   = exReg.regWrite;
    bus.ex_mem_read    = exReg.memRead;
    bus.ex_mem_write   = exReg.memWrite;
  end

endmodule
